// File: rtl/multiword_add_seq_pkg.sv
// rtl/multiword_add_seq_pkg.sv - shared types and constants for multiword_add_seq
//
// Purpose: holds the packet-position state enum and the widths of the
// per-word side-band fields that travel with the operands and results.
package multiword_add_seq_pkg;

  // Position of the next accepted word within its packet.
  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } pkt_state_e;

  // Side-band bits carried with each operand word: first, cin, last.
  localparam int OP_META_W  = 3;
  // Side-band bits carried with each result word: last, co.
  localparam int RES_META_W = 2;

endpackage

// File: rtl/multiword_add_seq_mwas_slot.sv
// rtl/multiword_add_seq_mwas_slot.sv - generic single-entry valid/data register slot
//
// Purpose: one pipeline register with a valid flag. A load writes the data
// and sets valid. A clear drops valid and keeps the stale data. Load wins
// over clear, so a slot that is drained and refilled in the same cycle stays
// full.
// Ports:
//   clk, rst : clock, synchronous active-high reset (valid and data to 0)
//   load     : capture d and set valid
//   clear    : drop valid (ignored when load is high)
//   d        : DW-bit data in
//   valid    : slot holds a live entry
//   q        : DW-bit registered data
module mwas_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d,
  output logic          valid,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - sequencer for multi-word addition through an external adder
//
// Purpose: accepts operand words least-significant first, presents them one
// at a time to an external combinational WIDTH-bit adder, and chains the
// carry from word to word within a packet. The first word of every packet
// uses the packet carry-in, so no carry crosses a packet boundary. There are
// two register stages: the operand slot feeds the adder, and the result slot
// feeds the output.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : operand handshake
//   in_a, in_b                   : operand words (WIDTH bits)
//   in_cin                       : packet carry-in, used with the first word only
//   in_last                      : final word of the packet
//   add_a, add_b, add_ci         : registered operands and carry to the adder
//   add_sum, add_co              : combinational adder result
//   out_valid/out_ready          : result handshake
//   out_sum, out_last, out_co    : result word, last flag, packet carry-out
//   pkt_count                    : packets fully delivered (wraps)
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_co,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int OP_W  = 2 * WIDTH + OP_META_W;
  localparam int RES_W = WIDTH + RES_META_W;

  pkt_state_e state;
  logic       carry_reg;

  logic             op_v;
  logic [OP_W-1:0]  op_d;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_first;
  logic             op_cin;
  logic             op_last;

  logic [RES_W-1:0] res_d;
  logic [RES_W-1:0] res_q;

  logic advance;
  logic in_hs;
  logic out_hs;

  // The operand slot moves forward when the result slot is empty or is
  // being drained in this same cycle.
  assign advance = op_v & (~out_valid | out_ready);
  // The rst term keeps the producer from seeing a handshake that the
  // reset would discard.
  assign in_ready = ~rst & (~op_v | advance);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  // op_first is captured from the packet state at accept time, so the adder
  // stage never needs to look at the live FSM.
  assign op_d = {in_a, in_b, (state == ST_FIRST), in_cin, in_last};
  assign {op_a, op_b, op_first, op_cin, op_last} = op_q;

  mwas_slot #(.DW(OP_W)) u_op_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (in_hs),
    .clear (advance),
    .d     (op_d),
    .valid (op_v),
    .q     (op_q)
  );

  assign add_a  = op_a;
  assign add_b  = op_b;
  assign add_ci = op_first ? op_cin : carry_reg;

  // Only the final word reports a carry-out. Intermediate carries are
  // consumed internally.
  assign res_d = {add_sum, op_last, op_last & add_co};
  assign {out_sum, out_last, out_co} = res_q;

  mwas_slot #(.DW(RES_W)) u_res_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (out_hs),
    .d     (res_d),
    .valid (out_valid),
    .q     (res_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FIRST;
      carry_reg <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (in_hs) begin
        state <= in_last ? ST_FIRST : ST_MID;
      end
      // The carry stored after a packet's last word is never used, because
      // the next word is a first word and selects op_cin instead.
      if (advance) begin
        carry_reg <= add_co;
      end
      if (out_hs && out_last) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - scoreboard testbench for multiword_add_seq
module tb_multiword_add_seq;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_last;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_ci;
  logic [W-1:0]  add_sum;
  logic          add_co;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_last;
  logic          out_co;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  // External combinational adder
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

  multiword_add_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_co    (out_co),
    .pkt_count (pkt_count)
  );

  logic [W+1:0]  exp_q[$];
  logic [CW-1:0] exp_pkts;
  logic [W-1:0]  pa[4];
  logic [W-1:0]  pb[4];
  int            total = 0;
  int            bad = 0;
  int            stalls = 0;
  bit            rnd_mode = 1'b0;
  string         cur_test = "reset";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_when_idle", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_sum", out_sum, e[W+1:2]);
          check_eq("out_last", out_last, e[1]);
          check_eq("out_co", out_co, e[0]);
          if (e[1]) exp_pkts = exp_pkts + 1'b1;
        end
      end
    end
  end

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    in_valid = 1'b0;
    if (!done) check_eq("in_hs_timeout", 0, 1);
  endtask

  // Reference: whole packet as one wide integer addition
  task automatic send_pkt(input int n, input logic cin);
    logic [32:0] aa, bb, tot;
    logic        lst;
    aa = '0;
    bb = '0;
    for (int i = 0; i < n; i++) begin
      aa[8*i +: 8] = pa[i];
      bb[8*i +: 8] = pb[i];
    end
    tot = aa + bb + {32'd0, cin};
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1);
      exp_q.push_back({tot[8*i +: 8], lst, lst & tot[8*n]});
    end
    for (int i = 0; i < n; i++) begin
      send_word(pa[i], pb[i], (i == 0) ? cin : 1'b0, (i == n - 1));
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 400 && !empty; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) empty = 1'b1;
    end
    if (!empty) check_eq("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_pkts  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("in_ready", in_ready, 0);
    check_eq("out_valid", out_valid, 0);
    check_eq("out_sum", out_sum, 0);
    check_eq("out_last", out_last, 0);
    check_eq("out_co", out_co, 0);
    check_eq("add_a", add_a, 0);
    check_eq("add_b", add_b, 0);
    check_eq("pkt_count", pkt_count, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    cur_test = "two_word";
    pa[0] = 8'hFF; pb[0] = 8'h01;
    pa[1] = 8'h00; pb[1] = 8'h00;
    send_pkt(2, 1'b0);
    drain();
    check_eq("pkt_count", pkt_count, 1);

    cur_test = "single_cin";
    pa[0] = 8'hFF; pb[0] = 8'h00;
    send_pkt(1, 1'b1);
    drain();
    check_eq("pkt_count", pkt_count, 2);

    cur_test = "three_word";
    pa[0] = 8'hFF; pb[0] = 8'h01;
    pa[1] = 8'hFF; pb[1] = 8'h00;
    pa[2] = 8'hFF; pb[2] = 8'h00;
    send_pkt(3, 1'b0);
    drain();
    check_eq("pkt_count", pkt_count, 3);

    cur_test = "backpressure";
    out_ready = 1'b0;
    fork
      send_pkt(3, 1'b0);
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          check_eq("in_ready", in_ready, 0);
          check_eq("out_valid", out_valid, 1);
          check_eq("out_sum", out_sum, 8'h00);
          check_eq("add_a", add_a, 8'hFF);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("pkt_count", pkt_count, 4);

    cur_test = "mid_reset";
    out_ready = 1'b0;
    send_word(8'hFF, 8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("in_ready_rst", in_ready, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_pkts  = '0;
    exp_q.delete();
    @(negedge clk);
    check_eq("out_valid_after_rst", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pa[0] = 8'h05; pb[0] = 8'h03;
    send_pkt(1, 1'b0);
    drain();
    check_eq("pkt_count", pkt_count, 1);

    cur_test = "back_to_back";
    stalls = 0;
    pa[0] = 8'hFF; pb[0] = 8'h01;
    pa[1] = 8'hFF; pb[1] = 8'h00;
    send_pkt(2, 1'b0);
    pa[0] = 8'h01; pb[0] = 8'h02;
    pa[1] = 8'h03; pb[1] = 8'h04;
    send_pkt(2, 1'b0);
    check_eq("stalls", stalls, 0);
    drain();
    check_eq("pkt_count", pkt_count, 3);

    cur_test = "random";
    rnd_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        pa[i] = 8'($urandom);
        pb[i] = 8'($urandom);
      end
      send_pkt(n, 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    check_eq("pkt_count_wrap", pkt_count, exp_pkts);
    check_eq("pkt_count_abs", pkt_count, 4'(23));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
